// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: opcodes, control-rod bits, fetch states.
// Optional redirect counter in instr_fetch is enabled by INSTR_FETCH_REDIRECT_CNT_EN.
package instr_fetch_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_INC = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0110;
    localparam logic [3:0] OP_ST  = 4'b1010;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_RES = 4'b1100;
    localparam logic [3:0] OP_LD  = 4'b1101;
    localparam logic [3:0] OP_JMP = 4'b1111;

    localparam int ROD_ALU_LO   = 0;
    localparam int ROD_ALU_HI   = 2;
    localparam int ROD_BEQ      = 3;
    localparam int ROD_READMEM  = 4;
    localparam int ROD_MEMWRITE = 5;
    localparam int ROD_REGWRITE = 6;
    localparam int ROD_JMP      = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_FLUSH
    } fetch_state_e;

    function automatic logic rod_take(
        input logic jmp,
        input logic beq,
        input logic zero
    );
        return jmp | (beq & zero);
    endfunction

endpackage

// File: rtl/instr_fetch_pc.sv
// Program counter register: redirect load has priority over sequential increment.
// Increment wraps modulo 2^AW.
module instr_fetch_pc
    import instr_fetch_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [AW-1:0] i_target,
    input  logic          i_inc,
    output logic [AW-1:0] o_pc
);

    logic [AW-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + AW'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC generation, imem handshake, stall hold and JMP/BEQ redirect with flush.
// Define INSTR_FETCH_REDIRECT_CNT_EN to add the saturating redirect_cnt output.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int AW = 8,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          imem_valid,
    input  logic          stall,
    input  logic [7:0]    control_rod,
    input  logic          cmp_zero,
    input  logic [AW-1:0] branch_target,
    output logic [IW-1:0] instr,
    output logic [3:0]    opcode,
    output logic          instr_valid,
    output logic [AW-1:0] pc_out
`ifdef INSTR_FETCH_REDIRECT_CNT_EN
    ,
    output logic [15:0]   redirect_cnt
`endif
);

    fetch_state_e  r_state;
    fetch_state_e  w_next;
    logic [IW-1:0] r_instr;
    logic [AW-1:0] r_pc_out;
    logic          r_valid;
    logic [AW-1:0] w_pc;
    logic          w_active;
    logic          w_take;
    logic          w_accept;
    logic          w_unused_rod;

    assign w_unused_rod = ^{control_rod[6:4], control_rod[2:0]};

    // The rod lags the opcode by a cycle, so it is only trusted in FETCH/HOLD
    assign w_active = (r_state == ST_FETCH) || (r_state == ST_HOLD);
    assign w_take   = w_active &
                      rod_take(control_rod[ROD_JMP], control_rod[ROD_BEQ], cmp_zero);
    assign w_accept = (r_state == ST_FETCH) && imem_valid && !w_take;

    instr_fetch_pc #(.AW(AW)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_take),
        .i_target (branch_target),
        .i_inc    (w_accept),
        .o_pc     (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        case (r_state)
            ST_IDLE:  w_next = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (w_take) begin
                    w_next = ST_FLUSH;
                end else if (imem_valid) begin
                    w_next = stall ? ST_HOLD : ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (w_take) begin
                    w_next = ST_FLUSH;
                end else if (!stall) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FLUSH: w_next = ST_FETCH;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr  <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
        end else if (w_take) begin
            r_instr <= {OP_NOP, {(IW-4){1'b0}}};
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_instr  <= imem_rdata;
            r_pc_out <= w_pc;
            r_valid  <= 1'b1;
        end
    end

`ifdef INSTR_FETCH_REDIRECT_CNT_EN
    logic [15:0] r_redirect_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_cnt <= '0;
        end else if (w_take && (r_redirect_cnt != 16'hFFFF)) begin
            r_redirect_cnt <= r_redirect_cnt + 16'd1;
        end
    end

    assign redirect_cnt = r_redirect_cnt;
`endif

    assign imem_addr   = w_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[IW-1:IW-4];
    assign instr_valid = r_valid;
    assign pc_out      = r_pc_out;

endmodule
